// File: rtl/spi_slave_sysclk.sv
// -----------------------------------------------------------------------------
// spi_slave_sysclk
// SPI mode-0 responder running entirely on the system clock. sclk, cs_n and
// mosi are oversampled through a synchronizer chain. {rw, addr, data} frames
// (LSB first) are decoded into a local register file. Read data is returned
// on miso, LSB first, during the sclk cycles that follow the command frame.
//
// Optional feature: define SPI_SLV_FRAME_ERR_EN to add the frame_err pulse and
// the saturating err_cnt counter for frames aborted by an early cs_n rise.
// -----------------------------------------------------------------------------
module spi_slave_sysclk #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-2:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_rdata,
`ifdef SPI_SLV_FRAME_ERR_EN
    output logic                  frame_err,
    output logic [7:0]            err_cnt,
`endif
    output logic                  wr_pulse,
    output logic                  rd_pulse
);

    localparam int AW    = DATA_WIDTH - 1;           // address width
    localparam int FW    = 2 * DATA_WIDTH;           // frame width
    localparam int DEPTH = 2 ** AW;                  // register file depth
    localparam int CW    = $clog2(FW + 1);           // frame bit counter width
    localparam int RCW   = $clog2(DATA_WIDTH + 1);   // response fall counter width

    localparam logic [CW-1:0]  LAST_BIT  = CW'(FW - 1);
    localparam logic [RCW-1:0] RESP_DONE = RCW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_RESP,
        ST_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizers. Bit 0 = sclk, bit 1 = cs_n, bit 2 = mosi.
    // All stages reset to 0 so that a cs_n held low across reset does not
    // produce a false falling edge; a cs_n that is high after reset shows up
    // as a rising edge, which IDLE ignores.
    // -------------------------------------------------------------------------
    logic [2:0] sync_reg [SYNC_STAGES];

    // Shift the three SPI inputs through the synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= {mosi, cs_n, sclk};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    // Edges are taken between the last two stages: stage S-2 is the newer
    // sample, stage S-1 the older one.
    logic sclk_new, sclk_old, cs_new, cs_old, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_new  = sync_reg[SYNC_STAGES-2][0];
    assign sclk_old  = sync_reg[SYNC_STAGES-1][0];
    assign cs_new    = sync_reg[SYNC_STAGES-2][1];
    assign cs_old    = sync_reg[SYNC_STAGES-1][1];
    // mosi taken from the same stage as the new sclk sample so the data bit
    // and its clock edge are aligned.
    assign mosi_s    = sync_reg[SYNC_STAGES-2][2];

    assign sclk_rise = sclk_new & ~sclk_old;
    assign sclk_fall = ~sclk_new & sclk_old;
    assign cs_rise   = cs_new & ~cs_old;
    assign cs_fall   = ~cs_new & cs_old;

    // -------------------------------------------------------------------------
    // FSM and datapath registers
    // -------------------------------------------------------------------------
    state_t                state_reg,    state_next;
    logic [FW-1:0]         shift_reg,    shift_next;
    logic [CW-1:0]         bit_cnt_reg,  bit_cnt_next;
    logic [DATA_WIDTH-1:0] tx_reg,       tx_next;
    logic [RCW-1:0]        resp_cnt_reg, resp_cnt_next;
    logic                  rd_pulse_reg, rd_pulse_next;

    // Frame as it will look once the current mosi bit is shifted in; on the
    // last bit this is the complete command, used to choose WRITE vs RESP and
    // to fetch read data without an extra cycle.
    logic [FW-1:0]         frame_shifted;
    logic [AW-1:0]         cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_rdata;

    // Register file and write port
    logic [DATA_WIDTH-1:0] regfile [DEPTH];
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DEPTH-1:0]      wr_sel;

    assign frame_shifted = {mosi_s, shift_reg[FW-1:1]};
    assign cmd_addr      = frame_shifted[FW-2:DATA_WIDTH];
    assign cmd_rdata     = regfile[cmd_addr];

    // WRITE lasts exactly one cycle and the shift register then holds the
    // complete frame.
    assign wr_en   = (state_reg == ST_WRITE);
    assign wr_addr = shift_reg[FW-2:DATA_WIDTH];
    assign wr_data = shift_reg[DATA_WIDTH-1:0];

    // State and datapath register update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= '0;
            resp_cnt_reg <= '0;
            rd_pulse_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            tx_reg       <= tx_next;
            resp_cnt_reg <= resp_cnt_next;
            rd_pulse_reg <= rd_pulse_next;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        tx_next       = tx_reg;
        resp_cnt_next = resp_cnt_reg;
        rd_pulse_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next   = ST_CMD;
                    shift_next   = '0;
                    bit_cnt_next = '0;
                end
            end

            ST_CMD: begin
                if (cs_rise) begin
                    // Partial frame: dropped without touching the register file
                    state_next = ST_IDLE;
                end else if (sclk_rise) begin
                    shift_next   = frame_shifted;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        if (mosi_s) begin
                            state_next = ST_WRITE;
                        end else begin
                            state_next    = ST_RESP;
                            tx_next       = cmd_rdata;
                            resp_cnt_next = '0;
                            rd_pulse_next = 1'b1;
                        end
                    end
                end
            end

            ST_WRITE: begin
                // A cs_n rise landing in this single cycle must not be missed
                state_next = cs_rise ? ST_IDLE : ST_DONE;
            end

            ST_RESP: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end else if (sclk_fall) begin
                    // The first fall closes the command's last bit and keeps
                    // bit 0 on miso; each later fall presents the next bit.
                    // The fall after the last response bit ends the response.
                    if (resp_cnt_reg == RESP_DONE) begin
                        state_next = ST_DONE;
                    end else begin
                        if (resp_cnt_reg != '0) begin
                            tx_next = tx_reg >> 1;
                        end
                        resp_cnt_next = resp_cnt_reg + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One-hot write select per register entry
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
        end
    endgenerate

    // Register file: full reset to RESET_VAL, single SPI write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regfile[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    regfile[i] <= wr_data;
                end
            end
        end
    end

    // Local read port is combinational; a write in the same cycle is seen
    // only on the following cycle.
    assign reg_rdata = regfile[reg_addr];

    // miso only carries data while a response is in progress
    assign miso     = (state_reg == ST_RESP) & tx_reg[0];
    assign wr_pulse = wr_en;
    assign rd_pulse = rd_pulse_reg;

`ifdef SPI_SLV_FRAME_ERR_EN
    logic       abort;
    logic       frame_err_reg;
    logic [7:0] err_cnt_reg;

    assign abort = cs_rise && ((state_reg == ST_CMD) || (state_reg == ST_RESP));

    // Abort pulse and saturating abort counter
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            frame_err_reg <= abort;
            if (abort && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign frame_err = frame_err_reg;
    assign err_cnt   = err_cnt_reg;
`endif

endmodule

// File: tb/tb_spi_slave_sysclk.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_sysclk
// Bench acting as an SPI mode-0 master (sclk = clk/10). Read expectations come
// from a local register model and are queued when a read is issued, then
// popped and compared when the response bits have been collected from miso.
// Build with SPI_SLV_FRAME_ERR_EN to also exercise frame_err / err_cnt.
// -----------------------------------------------------------------------------
module tb_spi_slave_sysclk;

    localparam int HALF = 5;   // clk cycles per sclk half period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [6:0] reg_addr = '0;
    logic [7:0] reg_rdata;
    logic       wr_pulse;
    logic       rd_pulse;
`ifdef SPI_SLV_FRAME_ERR_EN
    logic       frame_err;
    logic [7:0] err_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_cnt       = 0;
    int rd_cnt       = 0;
    int fe_cnt       = 0;

    logic [7:0] mdl [128];
    logic [7:0] exp_q [$];

    spi_slave_sysclk #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2),
        .RESET_VAL   (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .reg_addr  (reg_addr),
        .reg_rdata (reg_rdata),
`ifdef SPI_SLV_FRAME_ERR_EN
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
`endif
        .wr_pulse  (wr_pulse),
        .rd_pulse  (rd_pulse)
    );

    always #5 clk = ~clk;

    // Count DUT pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_pulse) wr_cnt++;
        if (rd_pulse) rd_cnt++;
`ifdef SPI_SLV_FRAME_ERR_EN
        if (frame_err) fe_cnt++;
`endif
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic shift_frame(input logic [15:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = frame[i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic read_bits(input int n, output logic [7:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            wait_clk(HALF);
            bits[i] = miso;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(4 * HALF);   // cs_n high for two sclk periods
    endtask

    task automatic spi_write(input logic [6:0] addr, input logic [7:0] data, input int nbits);
        cs_start();
        shift_frame({1'b1, addr, data}, nbits);
        cs_end();
        if (nbits == 16) mdl[addr] = data;
        $display("[TB] write addr=0x%02h data=0x%02h bits=%0d", addr, data, nbits);
    endtask

    task automatic spi_read(input logic [6:0] addr, input int extra);
        logic [7:0] got;
        exp_q.push_back(mdl[addr]);
        cs_start();
        shift_frame({1'b0, addr, 8'h00}, 16);
        read_bits(8, got);
        for (int i = 0; i < extra; i++) begin
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(2);
        check("miso_after_resp", {31'd0, miso}, 32'd0);
        cs_end();
        check("rd_data", {24'd0, got}, {24'd0, exp_q.pop_front()});
        $display("[TB] read  addr=0x%02h data=0x%02h extra_sclk=%0d", addr, got, extra);
    endtask

    initial begin
        int w0, r0, f0;
        logic [7:0] part;

        for (int i = 0; i < 128; i++) mdl[i] = 8'h00;

        // Reset state
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        reg_addr = 7'h05;
        wait_clk(2);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
        check("rst_rd_pulse", {31'd0, rd_pulse}, 32'd0);
        check("rst_rdata", {24'd0, reg_rdata}, 32'd0);
`ifdef SPI_SLV_FRAME_ERR_EN
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif

        // 1: simple write and local readback
        w0 = wr_cnt;
        spi_write(7'h05, 8'hA5, 16);
        check("t1_wr_pulses", wr_cnt - w0, 1);
        reg_addr = 7'h05;
        wait_clk(1);
        check("t1_rdata", {24'd0, reg_rdata}, 32'hA5);

        // 2: write then read back over SPI
        spi_write(7'h7F, 8'h3C, 16);
        r0 = rd_cnt;
        spi_read(7'h7F, 0);
        check("t2_rd_pulses", rd_cnt - r0, 1);

        // 3: frame aborted after 9 bits
        w0 = wr_cnt;
        f0 = fe_cnt;
        spi_write(7'h02, 8'h11, 9);
        check("t3_wr_pulses", wr_cnt - w0, 0);
        reg_addr = 7'h02;
        wait_clk(1);
        check("t3_rdata", {24'd0, reg_rdata}, 32'd0);
`ifdef SPI_SLV_FRAME_ERR_EN
        check("t3_frame_err", fe_cnt - f0, 1);
        check("t3_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif

        // 4: reset in the middle of a read response
        cs_start();
        shift_frame({1'b0, 7'h05, 8'h00}, 16);
        read_bits(3, part);
        check("t4_partial", {24'd0, part}, 32'h05);
        rst = 1'b1;
        wait_clk(3);
        check("t4_miso_rst", {31'd0, miso}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
        reg_addr = 7'h05;
        wait_clk(1);
        check("t4_rdata", {24'd0, reg_rdata}, 32'd0);
        cs_n = 1'b1;
        wait_clk(4 * HALF);
        $display("[TB] reset during read of addr=0x05");
`ifdef SPI_SLV_FRAME_ERR_EN
        check("t4_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        r0 = rd_cnt;
        spi_read(7'h05, 0);
        check("t4_rd_pulses", rd_cnt - r0, 1);

        // 5: back-to-back writes
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            spi_write(7'(16 + i), 8'(i + 1), 16);
        end
        check("t5_wr_pulses", wr_cnt - w0, 4);
        for (int i = 0; i < 4; i++) begin
            reg_addr = 7'(16 + i);
            wait_clk(1);
            check("t5_rdata", {24'd0, reg_rdata}, 32'(i + 1));
        end

        // 6: read of unwritten address, extra sclk in DONE
        r0 = rd_cnt;
        w0 = wr_cnt;
        spi_read(7'h40, 3);
        check("t6_rd_pulses", rd_cnt - r0, 1);
        check("t6_wr_pulses", wr_cnt - w0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
